// File: rtl/rssb_pkg.sv
// rssb_pkg: shared FSM encoding, memory-mapped cell addresses and the HALT word helper
package rssb_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPER,
    S_EXEC,
    S_WAIT_IN,
    S_WAIT_OUT,
    S_HALT
  } state_t;
  localparam int unsigned ADDR_PC   = 0;
  localparam int unsigned ADDR_ACC  = 1;
  localparam int unsigned ADDR_ZERO = 2;
  localparam int unsigned ADDR_IN   = 3;
  localparam int unsigned ADDR_OUT  = 4;
  function automatic logic [63:0] halt_word(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction
endpackage

// File: rtl/rssb_mem.sv
// rssb_mem: single-port synchronous RAM, 1-cycle read, load port overrides the execution port
module rssb_mem #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [WIDTH-1:0]  ex_data,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic we;
  always_comb begin
    addr  = ld_sel ? ld_addr : ex_addr;
    wdata = ld_sel ? ld_data : ex_data;
    we    = ld_sel || ex_we;
  end
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/rssb_core_p.sv
// rssb_core_p: parametrised multi-cycle RSSB processor with memory-mapped PC/ACC/zero/in/out cells
// Define RSSB_INSTR_CNT_EN to add the saturating instr_cnt output.
module rssb_core_p
  import rssb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 5,
  parameter int START_PC = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              halted,
  output logic [WIDTH-1:0]  oacc,
  output logic [WIDTH-1:0]  omem,
  output logic [ADDR_W-1:0] oop1,
  output logic [ADDR_W-1:0] opc,
  output logic [WIDTH-1:0]  osub
`ifdef RSSB_INSTR_CNT_EN
  ,
  output logic [31:0]       instr_cnt
`endif
);
  localparam logic [ADDR_W-1:0] A_PC  = ADDR_W'(ADDR_PC);
  localparam logic [ADDR_W-1:0] A_ACC = ADDR_W'(ADDR_ACC);
  localparam logic [ADDR_W-1:0] A_IN  = ADDR_W'(ADDR_IN);
  localparam logic [ADDR_W-1:0] A_OUT = ADDR_W'(ADDR_OUT);
  state_t state, state_n;
  logic [WIDTH-1:0] rdata, acc, in_q, operand, diff;
  logic [ADDR_W-1:0] pc, op_addr, mem_addr, pc_seq;
  logic brw, brw_q, idle_like, ld_ok, go, halt_op, special;
  assign oacc = acc;
  assign opc  = pc;
  always_comb begin
    idle_like = state == S_IDLE || state == S_HALT;
    ld_ok     = idle_like && ld_en;
    go        = idle_like && start && !ld_en;
    halt_op   = 64'(rdata) == halt_word(WIDTH);
    op_addr   = rdata[ADDR_W-1:0];
    special   = oop1 <= A_OUT;
    operand   = oop1 == A_PC ? WIDTH'(pc) : oop1 == A_ACC ? acc : oop1 == A_IN ? in_q : special ? '0 : rdata;
    diff      = operand - acc;
    brw       = operand < acc;
    pc_seq    = pc + ((state == S_WAIT_OUT ? brw_q : brw) ? ADDR_W'(2) : ADDR_W'(1));
    mem_addr  = state == S_FETCH ? pc : state == S_OPER ? op_addr : oop1;
    in_ready  = state == S_WAIT_IN && in_valid;
    busy      = state inside {S_FETCH, S_OPER, S_EXEC, S_WAIT_IN, S_WAIT_OUT};
    halted    = state == S_HALT;
  end
  // rst gates both write paths so an aborted instruction never lands in memory
  rssb_mem #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .ld_sel (ld_ok && !rst),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ex_we  (state == S_EXEC && !special && !rst),
    .ex_addr(mem_addr),
    .ex_data(diff),
    .rdata  (rdata)
  );
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_HALT: state_n = go ? S_FETCH : state;
      S_FETCH:        state_n = S_OPER;
      S_OPER:         state_n = halt_op ? S_HALT : op_addr == A_IN ? S_WAIT_IN : S_EXEC;
      S_WAIT_IN:      state_n = in_valid ? S_EXEC : S_WAIT_IN;
      S_EXEC:         state_n = oop1 == A_OUT ? S_WAIT_OUT : S_FETCH;
      S_WAIT_OUT:     state_n = out_ready ? S_FETCH : S_WAIT_OUT;
      default:        state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= ADDR_W'(START_PC);
      acc       <= '0;
      omem      <= '0;
      oop1      <= '0;
      osub      <= '0;
      brw_q     <= 1'b0;
      in_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (go) pc <= ADDR_W'(START_PC);
      if (state == S_OPER && !halt_op) oop1 <= op_addr;
      if (in_ready) in_q <= in_data;
      if (state == S_EXEC) begin
        omem  <= operand;
        osub  <= diff;
        acc   <= diff;
        brw_q <= brw;
        if (oop1 == A_OUT) begin
          out_valid <= 1'b1;
          out_data  <= diff;
        end else begin
          pc <= oop1 == A_PC ? diff[ADDR_W-1:0] : pc_seq;
        end
      end
      // output write retires only once the sink takes it
      if (state == S_WAIT_OUT && out_ready) begin
        out_valid <= 1'b0;
        pc        <= pc_seq;
      end
    end
  end
`ifdef RSSB_INSTR_CNT_EN
  logic step_done;
  assign step_done = (state == S_EXEC && oop1 != A_OUT) || (state == S_WAIT_OUT && out_ready);
  always_ff @(posedge clk) begin
    if (rst || go) instr_cnt <= '0;
    else if (step_done && instr_cnt != '1) instr_cnt <= instr_cnt + 32'd1;
  end
`endif
endmodule

// File: doc/rssb_core_p.md
Name: rssb_core_p

Overview:
- Parametrised multi-cycle RSSB (reverse-subtract, skip-if-borrow) one-instruction processor.
- Next generation of the fixed 8-bit rssb core.
- Adds:
  - configurable data and address width
  - memory-mapped PC/ACC/zero/input/output cells with valid/ready handshakes
  - program-load port, start/halt control, reserved HALT word
- Sits as top-level compute block; debug outputs keep the existing oacc/omem/oop1/opc/osub names.

Parameters:
- WIDTH, 8: data word width in bits; must be >= ADDR_W.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W words of unified memory.
- START_PC, 5: PC value after reset and at each start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from IDLE or HALT.
- ld_en  in  1  program-load write strobe; honoured only in IDLE/HALT.
- ld_addr  in  ADDR_W  load address.
- ld_data  in  WIDTH  load data.
- in_valid  in  1  input-port data valid.
- in_data  in  WIDTH  input-port data.
- in_ready  out  1  input consumed this cycle.
- out_valid  out  1  output-port data valid.
- out_data  out  WIDTH  output-port data.
- out_ready  in  1  sink accepts out_data.
- busy  out  1  high in FETCH/OPER/EXEC/WAIT states.
- halted  out  1  high in HALT.
- oacc  out  WIDTH  accumulator.
- omem  out  WIDTH  operand value read in the current/last instruction.
- oop1  out  ADDR_W  operand address of the current instruction.
- opc  out  ADDR_W  program counter.
- osub  out  WIDTH  last subtraction result.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; pc=START_PC; all other registers/outputs 0.
  - Memory contents are not cleared.
  - Reset in any state, including WAIT_IN/WAIT_OUT, aborts immediately; no pending write completes.
- Memory: single-port synchronous RAM, 1-cycle read latency.
- Load port: write mem[ld_addr]=ld_data in IDLE/HALT. ld_en has priority over start in the same cycle; that start is dropped.
- Special addresses (RAM words 0..4 are shadowed):
  - 0: read returns zero-extended pc; write sets pc.
  - 1: read returns acc.
  - 2: reads 0; writes discarded.
  - 3: read stalls for the input handshake; writes discarded.
  - 4: read returns 0; write drives the output handshake.
- FSM states: IDLE, FETCH, OPER, EXEC, WAIT_IN, WAIT_OUT, HALT.
  - IDLE/HALT + start: pc=START_PC, go to FETCH.
  - FETCH: read mem[pc]; go to OPER.
  - OPER:
    - Instruction word all-ones: go to HALT; pc unchanged.
    - Otherwise oop1 = word[ADDR_W-1:0]; issue operand read; go to EXEC, or WAIT_IN if oop1==3.
  - WAIT_IN: while in_valid=0 hold. When in_valid=1: in_ready=1 for exactly that cycle, operand=in_data, go to EXEC.
  - EXEC:
    - omem=operand.
    - osub = (operand - acc) mod 2**WIDTH; borrow = operand < acc (unsigned); acc=osub.
    - Write osub to mem[oop1] unless oop1 is 0..4.
    - If oop1==4: out_data=osub, out_valid=1, go to WAIT_OUT; pc update deferred.
    - Else pc update, then FETCH.
  - WAIT_OUT: out_valid/out_data held stable until out_ready=1. Then out_valid=0 next cycle, pc update, FETCH.
- PC update:
  - If oop1==0: pc = osub[ADDR_W-1:0]; no skip.
  - Else pc = pc + (borrow ? 2 : 1) mod DEPTH; wraps DEPTH-1 -> 0.
- Latency: 3 cycles per instruction when not stalled.
- HALT holds all registers; start re-runs from START_PC.

Optional Feature:
- Macro RSSB_INSTR_CNT_EN.
- Defined:
  - Adds output port instr_cnt[31:0].
  - Increments on every EXEC completion (in WAIT_OUT: on handshake).
  - Saturates at all-ones; cleared by rst and by start.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package rssb_pkg holds:
  - state enum typedef
  - constants ADDR_PC=0, ADDR_ACC=1, ADDR_ZERO=2, ADDR_IN=3, ADDR_OUT=4
  - HALT word (all-ones) helper function
- One sub-module rssb_mem: parametrised single-port synchronous RAM with load/exec address-data mux.

Test Plan (WIDTH=8, ADDR_W=5):
- Reset held 2 cycles, then released -> oacc=0, opc=5, busy=0, halted=0, out_valid=0, in_ready=0.
- Load mem[5]=20, mem[20]=7, mem[6]=0xFF; pulse start -> after 3 cycles oacc=7, osub=7, mem[20]=7, opc=6; then halted=1, opc stays 6.
- Borrow skip: acc=7, mem[6]=21, mem[21]=3 -> osub=0xFC, mem[21]=0xFC, opc 6->8.
- Output stall: acc=0xFC, instruction word 4 -> out_valid=1, out_data=0x04. Hold out_ready=0 for 5 cycles -> opc frozen, out_data stable. Raise out_ready -> opc += 2 (borrow).
- Input: acc=4, instruction word 3, in_valid low 4 cycles -> stall. Then in_data=9, in_valid=1 -> in_ready high 1 cycle, oacc=5, pc += 1.
- PC write plus mid-run reset: at pc=10, acc=0xF6, instruction word 0 -> opc=20. Assert rst in next OPER -> IDLE, opc=5, oacc=0, memory intact.
